// File: rtl/dcache.sv
// dcache: 8-line direct-mapped write-back, write-allocate byte cache.
// Define DCACHE_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module dcache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        C_WRITE,
    input  logic        C_READ,
    input  logic [7:0]  C_ADDRESS,
    input  logic [7:0]  C_WRITEDATA,
    output logic [7:0]  C_READDATA,
    output logic        C_BUSYWAIT,
    output logic        mem_write,
    output logic        mem_read,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_valid, r_dirty;
    logic [2:0]  r_tag [8];
    logic [31:0] r_data [8];
    logic [31:0] r_fill;
    logic [2:0]  w_index, w_tag;
    logic [1:0]  w_off;
    logic        w_hit, w_req, w_acc, w_miss;

    assign w_tag      = C_ADDRESS[7:5];
    assign w_index    = C_ADDRESS[4:2];
    assign w_off      = C_ADDRESS[1:0];
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_req      = C_READ || C_WRITE;
    assign w_acc      = w_req && r_state == IDLE && w_hit;
    assign w_miss     = w_req && r_state == IDLE && !w_hit;
    assign C_BUSYWAIT = w_req && !(r_state == IDLE && w_hit);
    assign C_READDATA = r_data[w_index][{w_off, 3'b000} +: 8];

    always_comb begin
        w_next        = r_state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = C_ADDRESS[7:2];
        mem_writedata = r_data[w_index];
        case (r_state)
            IDLE: if (w_miss) w_next = (r_valid[w_index] && r_dirty[w_index]) ? WRITE_BACK : MEM_READ;
            WRITE_BACK: begin
                mem_write   = 1'b1;
                mem_address = {r_tag[w_index], w_index};
                if (!mem_busywait) w_next = MEM_READ;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                if (!mem_busywait) w_next = UPDATE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Tags and data survive reset; only valid/dirty and the FSM are cleared.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == MEM_READ && !mem_busywait) r_fill <= mem_readdata;
            if (r_state == UPDATE) begin
                r_data[w_index]  <= r_fill;
                r_tag[w_index]   <= w_tag;
                r_valid[w_index] <= 1'b1;
                r_dirty[w_index] <= 1'b0;
            end
            if (w_acc && C_WRITE) begin
                r_data[w_index][{w_off, 3'b000} +: 8] <= C_WRITEDATA;
                r_dirty[w_index] <= 1'b1;
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // r_pending marks a refilled access so its retry hit is not counted as a hit.
    logic r_pending;
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (w_miss) begin
                r_pending <= 1'b1;
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
            if (w_acc) begin
                r_pending <= 1'b0;
                if (!r_pending && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed scoreboard bench for dcache with a latency-2 block memory model.
module tb_dcache;
    logic        CLK = 0, RESET = 0, C_WRITE = 0, C_READ = 0;
    logic [7:0]  C_ADDRESS = 0, C_WRITEDATA = 0;
    logic [7:0]  C_READDATA;
    logic        C_BUSYWAIT, mem_write, mem_read;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 0;
    logic        mem_busywait = 1;
`ifdef DCACHE_PERF_CNT_EN
    logic [15:0] hit_count, miss_count;
`endif

    dcache dut (
        .CLK(CLK), .RESET(RESET), .C_WRITE(C_WRITE), .C_READ(C_READ),
        .C_ADDRESS(C_ADDRESS), .C_WRITEDATA(C_WRITEDATA), .C_READDATA(C_READDATA),
        .C_BUSYWAIT(C_BUSYWAIT), .mem_write(mem_write), .mem_read(mem_read),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef DCACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {bit wr; logic [5:0] a; logic [31:0] d;} mtx_t;
    mtx_t        mq[$];
    mtx_t        e;
    logic [7:0]  rq[$];
    logic [31:0] mem [64];
    int          n_chk = 0, n_pass = 0, cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic mx(input bit w, input logic [5:0] a, input logic [31:0] d);
        mtx_t t;
        t.wr = w; t.a = a; t.d = d;
        mq.push_back(t);
    endtask

    // Memory: completes a held request on its second busy cycle, then scores it.
    always @(negedge CLK) begin
        if (!mem_busywait) begin
            mem_busywait = 1;
            cnt = 0;
        end else if (mem_read || mem_write) begin
            cnt++;
            if (cnt == 2) begin
                mem_busywait = 0;
                check("mem_rw_exclusive", {31'd0, mem_read && mem_write}, 32'd0);
                if (mq.size() == 0) begin
                    n_chk++;
                    $display("FAIL mem_unexpected: got wr=%0b addr=0x%0h expected no request", mem_write, mem_address);
                end else begin
                    e = mq.pop_front();
                    check("mem_kind", {31'd0, mem_write}, {31'd0, e.wr});
                    check("mem_addr", {26'd0, mem_address}, {26'd0, e.a});
                    if (e.wr) check("mem_wdata", mem_writedata, e.d);
                end
                if (mem_write) mem[mem_address] = mem_writedata;
                else mem_readdata = mem[mem_address];
            end
        end else cnt = 0;
    end

    always @(negedge CLK) begin
        if (C_READ && !C_WRITE && !C_BUSYWAIT) begin
            if (rq.size() == 0) begin
                n_chk++;
                $display("FAIL read_unexpected: got 0x%0h expected no read", C_READDATA);
            end else check("read_data", {24'd0, C_READDATA}, {24'd0, rq.pop_front()});
        end
    end

    task automatic access(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] d, output int w);
        @(posedge CLK); #1;
        C_WRITE = wr; C_READ = rd; C_ADDRESS = a; C_WRITEDATA = d;
        w = 0;
        forever begin
            @(negedge CLK);
            if (!C_BUSYWAIT) break;
            w++;
            if (w >= 100) begin
                n_chk++;
                $display("FAIL access_timeout: addr 0x%0h still busy after %0d cycles, expected done", a, w);
                break;
            end
        end
        @(posedge CLK); #1;
        C_WRITE = 0; C_READ = 0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input bit hit);
        int w;
        rq.push_back(exp);
        access(0, 1, a, 0, w);
        if (hit) check($sformatf("hit_latency_rd_%0h", a), w, 0);
        else check($sformatf("miss_stall_rd_%0h", a), {31'd0, w > 0}, 1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input bit hit);
        int w;
        access(1, 0, a, d, w);
        if (hit) check($sformatf("hit_latency_wr_%0h", a), w, 0);
        else check($sformatf("miss_stall_wr_%0h", a), {31'd0, w > 0}, 1);
    endtask

    initial begin
        int w;
        // Each memory byte holds its own byte address, so expected fills are easy to read.
        for (int b = 0; b < 64; b++)
            mem[b] = {8'(b * 4 + 3), 8'(b * 4 + 2), 8'(b * 4 + 1), 8'(b * 4)};
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busywait", {31'd0, C_BUSYWAIT}, 0);
        check("rst_mem_read", {31'd0, mem_read}, 0);
        check("rst_mem_write", {31'd0, mem_write}, 0);
        @(posedge CLK); #1 RESET = 1;
        @(negedge CLK);
        check("idle_busywait", {31'd0, C_BUSYWAIT}, 0);

        mx(0, 6'h01, 0);              rd(8'h05, 8'h05, 0);
`ifdef DCACHE_PERF_CNT_EN
        check("perf_miss_after_cold", {16'd0, miss_count}, 1);
        check("perf_hit_after_cold", {16'd0, hit_count}, 0);
`endif
        rd(8'h05, 8'h05, 1);
`ifdef DCACHE_PERF_CNT_EN
        check("perf_miss", {16'd0, miss_count}, 1);
        check("perf_hit", {16'd0, hit_count}, 1);
`endif
        wr(8'h05, 8'hAB, 1);
        rd(8'h05, 8'hAB, 1);
        mx(1, 6'h01, 32'h0706AB04); mx(0, 6'h09, 0); rd(8'h25, 8'h25, 0);
        mx(0, 6'h00, 0);              rd(8'h00, 8'h00, 0);
        mx(0, 6'h08, 0);              rd(8'h20, 8'h20, 0);
        mx(0, 6'h01, 0);              rd(8'h05, 8'hAB, 0);
        mx(0, 6'h07, 0);              wr(8'h1F, 8'h5C, 0);
        rd(8'h1F, 8'h5C, 1);
        rd(8'h1C, 8'h1C, 1);
        access(1, 1, 8'h1C, 8'h77, w);
        check("rw_both_hit_latency", w, 0);
        rd(8'h1C, 8'h77, 1);

        // Abort a refill with reset, then the same access must miss again.
        mx(0, 6'h0E, 0); rq.push_back(8'h3A);
        @(posedge CLK); #1;
        C_READ = 1; C_ADDRESS = 8'h3A;
        w = 0;
        while (!mem_read && w < 100) begin
            @(posedge CLK); #1;
            w++;
        end
        check("reach_mem_read", {31'd0, mem_read}, 1);
        RESET = 0;
        @(posedge CLK); #1;
        check("abort_mem_read", {31'd0, mem_read}, 0);
        check("abort_mem_write", {31'd0, mem_write}, 0);
        RESET = 1;
        check("abort_remiss_busy", {31'd0, C_BUSYWAIT}, 1);
        w = 0;
        forever begin
            @(negedge CLK);
            if (!C_BUSYWAIT || w >= 100) break;
            w++;
        end
        check("abort_retry_done", {31'd0, C_BUSYWAIT}, 0);
        @(posedge CLK); #1 C_READ = 0;

        rd(8'h3A, 8'h3A, 1);
        mx(0, 6'h01, 0); rd(8'h05, 8'hAB, 0);
        mx(0, 6'h07, 0); rd(8'h1C, 8'h1C, 0);

        repeat (3) @(posedge CLK);
        check("read_queue_drained", rq.size(), 0);
        check("mem_queue_drained", mq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog timeout");
    end
endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: RESET  in  1  synchronous, active-low reset (0 = reset, sampled on rising CLK).
REQ-003 SHALL have ports: C_WRITE  in  1  CPU write request, held until C_BUSYWAIT low.
REQ-004 SHALL have ports: C_READ  in  1  CPU read request, held until C_BUSYWAIT low.
REQ-005 SHALL have ports: C_ADDRESS  in  8  byte address {tag[7:5], index[4:2], offset[1:0]}.
REQ-006 SHALL have ports: C_WRITEDATA  in  8  byte to store.
REQ-007 SHALL have ports: C_READDATA  out  8  byte read.
REQ-008 SHALL have ports: C_BUSYWAIT  out  1  CPU stall.
REQ-009 SHALL have ports: mem_write  out  1  block write request to memory.
REQ-010 SHALL have ports: mem_read  out  1  block read request to memory.
REQ-011 SHALL have ports: mem_address  out  6  block address {tag, index}.
REQ-012 SHALL have ports: mem_writedata  out  32  victim block, byte 0 in [7:0].
REQ-013 SHALL have ports: mem_readdata  in  32  fetched block, byte 0 in [7:0].
REQ-014 SHALL have ports: mem_busywait  in  1  memory busy; request complete when it is low while request is held.

Function
REQ-015 SHALL be direct-mapped, 8 lines x 4 bytes, per line valid bit, dirty bit, 3-bit tag; write-back, write-allocate.
REQ-016 SHALL compute hit = valid[index] and tag[index]==C_ADDRESS[7:5], combinationally.
REQ-017 SHALL drive C_BUSYWAIT = (C_READ or C_WRITE) and not (state==IDLE and hit); low when no request.
REQ-018 Read hit: C_READDATA = selected byte combinationally in the same cycle; no state change.
REQ-019 Write hit: byte written at next rising edge; dirty[index]=1; other bytes unchanged.
REQ-020 C_READ and C_WRITE both high SHALL be treated as a write.
REQ-021 FSM states IDLE, WRITE_BACK, MEM_READ, UPDATE.
REQ-022 IDLE -> WRITE_BACK on miss with valid and dirty victim; IDLE -> MEM_READ on miss otherwise.
REQ-023 WRITE_BACK: mem_write=1, mem_address={old tag, index}, mem_writedata=victim block; -> MEM_READ when mem_busywait=0.
REQ-024 MEM_READ: mem_read=1, mem_address=C_ADDRESS[7:2]; -> UPDATE when mem_busywait=0.
REQ-025 UPDATE: single cycle; line <= mem_readdata captured at the MEM_READ exit edge; tag set; valid=1; dirty=0; -> IDLE.
REQ-026 After UPDATE, the retried request SHALL hit in IDLE (one extra cycle).
REQ-027 mem_read and mem_write SHALL never be high together; both 0 in IDLE and UPDATE.
REQ-028 Outputs SHALL be registered-state decoded with no latches; mem_writedata and mem_address are don't-care when no request is active.

Reset
REQ-029 RESET=0 at a rising edge SHALL set state IDLE and clear all valid and dirty bits; tags and data are unchanged.
REQ-030 Reset mid-miss SHALL abort the miss: mem_read=mem_write=0 from that edge; no line is written.
REQ-031 During and after reset with no request, C_BUSYWAIT=0.

Configuration
REQ-032 With DCACHE_PERF_CNT_EN defined, the cache SHALL add outputs hit_count (out, 16) and miss_count (out, 16).
REQ-033 hit_count SHALL increment once per completed access that hit in IDLE on first evaluation.
REQ-034 miss_count SHALL increment once per IDLE miss transition.
REQ-035 hit_count and miss_count SHALL saturate at 0xFFFF and clear on reset.
REQ-036 Without DCACHE_PERF_CNT_EN, the ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-037 Cold read after reset, addr 0x05: C_BUSYWAIT=1 -> MEM_READ with mem_address=0x01 -> UPDATE -> C_READDATA=mem byte 1 of block 1, C_BUSYWAIT=0.
REQ-038 Write 0xAB to 0x05, then read 0x05: read hits in the same cycle, returns 0xAB, and no memory request occurs.
REQ-039 Dirty eviction: after the 0x05 write, read 0x25 (same index 1, tag 1) -> WRITE_BACK mem_address=0x01 with mem_writedata[15:8]=0xAB, then MEM_READ mem_address=0x09.
REQ-040 Clean eviction: read 0x00, then read 0x20 -> no WRITE_BACK; MEM_READ only, mem_write stays 0.
REQ-041 Assert RESET=0 during MEM_READ -> next edge: state IDLE, mem_read=0; re-read of the same address misses again.
REQ-042 With DCACHE_PERF_CNT_EN, the sequence of cold read + hit read yields miss_count=1 and hit_count=1.
